timer_responder: RTL and testbench
==================================

TIMER_RESPONDER -- requirements
Module: timer_responder

Interface
REQ-001 Parameter PRESCALE, default 1, number of clk cycles per COUNT decrement; legal range 1..65535.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 enable  in  1  request select; qualifies read/write.
REQ-005 byte_enable  in  4  per-byte write strobes; bit i covers writedata[8i+7:8i].
REQ-006 address  in  32  word address; bits [1:0] select the register, bits [31:2] ignored.
REQ-007 read  in  1  read request.
REQ-008 write  in  1  write request.
REQ-009 writedata  in  32  write data.
REQ-010 readdata  out  32  read data; valid only while ready=1.
REQ-011 ready  out  1  one-cycle completion pulse per accepted request.
REQ-012 irq  out  1  interrupt; equals STATUS.expired AND CTRL.irq_en.

Function
REQ-013 The register map SHALL be: 0 CTRL (bit0 run, bit1 auto_reload, bit2 irq_en, others read 0); 1 LOAD (32-bit R/W); 2 COUNT (read-only); 3 STATUS (bit0 expired, write-1-to-clear).
REQ-014 The bus FSM SHALL have states IDLE and RESP.
REQ-015 In IDLE, enable=1 with read=1 or write=1 SHALL be accepted: address, writedata, byte_enable and operation are captured, and the FSM moves to RESP.
REQ-016 In RESP, ready SHALL be 1 for exactly one cycle with readdata valid; the FSM then returns to IDLE; ready is 0 in all other cycles.
REQ-017 Requests presented while the FSM is in RESP SHALL be ignored; the requester holds signals until ready.
REQ-018 Latency SHALL be fixed: ready asserts in the cycle after acceptance; back-to-back requests complete every 2 cycles.
REQ-019 If read and write are both 1, the request SHALL be treated as a write, and readdata SHALL be 0.
REQ-020 Writes SHALL take effect in the RESP cycle and only update bytes whose byte_enable bit is 1; byte_enable=0000 performs no update but still completes.
REQ-021 Writing LOAD SHALL also load COUNT with the new LOAD value and reset the prescaler.
REQ-022 Writes to COUNT SHALL be ignored; readdata for writes SHALL be 0.
REQ-023 While CTRL.run=1, the prescaler SHALL count 0..PRESCALE-1 and COUNT SHALL decrement by 1 when the prescaler wraps.
REQ-024 When COUNT=0 at a decrement point with run=1: STATUS.expired SHALL be set; if auto_reload=1, COUNT SHALL load LOAD; otherwise run SHALL clear and COUNT SHALL stay 0.
REQ-025 If an expiry and a write-1-to-clear to STATUS occur in the same cycle, the set SHALL win.
REQ-026 If a LOAD write and a decrement occur in the same cycle, the LOAD write SHALL win.
REQ-027 With run=0, COUNT and the prescaler SHALL hold their values.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force: FSM=IDLE, ready=0, readdata=0, CTRL=0, LOAD=0, COUNT=0, STATUS=0, prescaler=0, irq=0.
REQ-029 Reset during RESP SHALL abort the transaction with no ready pulse and no register write.

Structure
REQ-030 A shared package timer_pkg SHALL hold the register index constants, the CTRL/STATUS bit positions and the FSM state enum.
REQ-031 The prescaler, COUNT and expiry logic SHALL live in the sub-module timer_core; timer_responder holds the bus FSM and the registers.

Verification
REQ-032 Reset, then read address 3 -> ready 1 cycle after acceptance, readdata=0x0, irq=0.
REQ-033 Write LOAD=0x3 with byte_enable=1111, then write CTRL=0x5 (PRESCALE=1) -> COUNT reads 3,2,1,0; expired=1 and irq=1 on the 4th decrement point; run clears.
REQ-034 Write LOAD=0xAABBCCDD then 0x11223344 with byte_enable=0101 -> LOAD reads 0xAA22CC44.
REQ-035 Use auto_reload with LOAD=2; time the STATUS write-1-to-clear to coincide with an expiry -> expired stays 1 and COUNT reloads to 2.
REQ-036 Assert read=1 and write=1 to address 1 with data 0x7 -> LOAD=0x7 and readdata=0 during ready.
REQ-037 Deassert rst_n in the RESP cycle of a write -> no ready pulse, and all registers read 0 after reset.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer responder: register indices, control/status
// bit positions, bus FSM states and a byte-lane merge helper.
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int STATUS_EXPIRED = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/timer_core.sv
// Prescaler and down-counter. Emits a one-cycle expire pulse and a stop request
// when the counter underflows without auto-reload.
module timer_core
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        auto_reload,
  input  logic        load_wr,
  input  logic [31:0] load_val,
  output logic [31:0] count,
  output logic        expire,
  output logic        stop
);

  localparam logic [15:0] PSC_MAX = 16'(PRESCALE - 1);

  logic [15:0] psc_q, psc_d;
  logic [31:0] count_q, count_d;
  logic        tick;

  always_comb begin
    psc_d   = psc_q;
    count_d = count_q;
    expire  = 1'b0;
    stop    = 1'b0;
    tick    = run && (psc_q == PSC_MAX);
    if (run) psc_d = tick ? 16'd0 : psc_q + 16'd1;
    if (tick) begin
      if (count_q == 32'd0) begin
        expire = 1'b1;
        if (auto_reload) count_d = load_val;
        else             stop    = 1'b1;
      end else begin
        count_d = count_q - 32'd1;
      end
    end
    // A LOAD write overrides whatever the decrement point decided.
    if (load_wr) begin
      count_d = load_val;
      psc_d   = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_q   <= '0;
      count_q <= '0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_responder.sv
// Register-mapped timer: two-state bus responder with fixed one-cycle latency,
// CTRL/LOAD/STATUS registers, and the counting logic in timer_core.
module timer_responder
  import timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        irq
);

  bus_state_e  state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        wr_q, wr_d;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic        exp_q, exp_d;

  logic        do_wr, load_wr, core_expire, core_stop;
  logic [31:0] count;
  logic        unused_addr;

  assign unused_addr = ^address[31:2];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: if (enable && (read || write)) begin
        addr_d  = address[1:0];
        wdata_d = writedata;
        be_d    = byte_enable;
        wr_d    = write;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register writes commit on the edge that closes the RESP cycle.
  always_comb begin
    do_wr   = (state_q == ST_RESP) && wr_q;
    load_wr = do_wr && (addr_q == REG_LOAD);
    load_d  = load_wr ? be_merge(load_q, wdata_q, be_q) : load_q;

    ctrl_d = ctrl_q;
    if (core_stop) ctrl_d[CTRL_RUN] = 1'b0;
    if (do_wr && (addr_q == REG_CTRL) && be_q[0]) ctrl_d = wdata_q[2:0];

    exp_d = exp_q;
    if (do_wr && (addr_q == REG_STATUS) && be_q[0] && wdata_q[STATUS_EXPIRED])
      exp_d = 1'b0;
    if (core_expire) exp_d = 1'b1;
  end

  always_comb begin
    ready    = (state_q == ST_RESP);
    readdata = '0;
    if (ready && !wr_q) begin
      case (addr_q)
        REG_CTRL:   readdata = {29'd0, ctrl_q};
        REG_LOAD:   readdata = load_q;
        REG_COUNT:  readdata = count;
        REG_STATUS: readdata = {31'd0, exp_q};
        default:    readdata = '0;
      endcase
    end
  end

  assign irq = exp_q & ctrl_q[CTRL_IRQ_EN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
      load_q  <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      exp_q   <= exp_d;
    end
  end

  timer_core #(.PRESCALE(PRESCALE)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (ctrl_q[CTRL_RUN]),
    .auto_reload (ctrl_q[CTRL_AUTO]),
    .load_wr     (load_wr),
    .load_val    (load_d),
    .count       (count),
    .expire      (core_expire),
    .stop        (core_stop)
  );

endmodule

// File: tb/tb_timer_responder.sv
// Scoreboard bench for timer_responder: a cycle-level register/timer model predicts
// every response; a negedge monitor compares whatever the DUT completes.
module tb_timer_responder;

  localparam int PRESCALE = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        ready;
  logic        irq;

  always #5 clk = ~clk;

  timer_responder #(.PRESCALE(PRESCALE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .byte_enable (byte_enable),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .ready       (ready),
    .irq         (irq)
  );

  typedef struct packed {
    logic [2:0]  ctrl;   // run, auto_reload, irq_en
    logic [31:0] load;
    logic [31:0] count;
    logic [31:0] psc;
    logic        exp;
  } mstate_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        irq;
  } resp_t;

  mstate_t m;
  resp_t   q[$];
  int      checks = 0;
  int      errors = 0;

  // One clock of the timer behaviour, then an optional register write landing on it.
  function automatic mstate_t step(input mstate_t s, input bit wr, input logic [1:0] a,
                                   input logic [31:0] d, input logic [3:0] be,
                                   output bit expired);
    mstate_t n = s;
    expired = 0;
    if (s.ctrl[0]) begin
      if (s.psc == PRESCALE - 1) begin
        n.psc = 0;
        if (s.count == 0) begin
          n.exp = 1'b1;
          expired = 1;
          if (s.ctrl[1]) n.count = s.load;
          else           n.ctrl[0] = 1'b0;
        end else begin
          n.count = s.count - 1;
        end
      end else begin
        n.psc = s.psc + 1;
      end
    end
    if (wr) begin
      case (a)
        2'd0: if (be[0]) n.ctrl = d[2:0];
        2'd1: begin
          for (int i = 0; i < 4; i++) if (be[i]) n.load[8*i +: 8] = d[8*i +: 8];
          n.count = n.load;
          n.psc   = 0;
        end
        2'd3: if (be[0] && d[0] && !expired) n.exp = 1'b0;
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] reg_val(input mstate_t s, input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, s.ctrl};
      2'd1:    return s.load;
      2'd2:    return s.count;
      default: return {31'd0, s.exp};
    endcase
  endfunction

  task automatic tick(input bit wr, input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    bit ex;
    @(posedge clk);
    m = step(m, wr, a, d, be, ex);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      enable = ($urandom_range(0, 1) == 1);
      read   = !enable && ($urandom_range(0, 1) == 1);
      write  = !enable && ($urandom_range(0, 1) == 1);
      tick(0, 2'd0, '0, '0);
    end
    enable = 0; read = 0; write = 0;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    mstate_t nx;
    bit ex;
    resp_t r;
    enable = 1; read = rd; write = wr;
    address = $urandom(); address[1:0] = a;
    writedata = d; byte_enable = be;
    nx = step(m, 0, 2'd0, '0, '0, ex);
    r.rdata = wr ? 32'd0 : reg_val(nx, a);
    r.irq   = nx.exp & nx.ctrl[2];
    q.push_back(r);
    tick(0, 2'd0, '0, '0);
    // Inputs wander during the response cycle; the captured request must stand.
    address = $urandom(); writedata = $urandom(); byte_enable = 4'($urandom());
    read = 1'($urandom()); write = 1'($urandom());
    tick(wr, a, d, be);
    enable = 0; read = 0; write = 0;
  endtask

  always @(negedge clk) begin
    if (ready) begin
      resp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: readdata=%h irq=%b with no request outstanding", readdata, irq);
      end else begin
        e = q.pop_front();
        if (readdata !== e.rdata || irq !== e.irq) begin
          errors++;
          $display("FAIL response: got readdata=%h irq=%b, expected readdata=%h irq=%b",
                   readdata, irq, e.rdata, e.irq);
        end
      end
    end
  end

  initial begin
    bit hit;
    m = '0;
    #2;
    checks++;
    if (ready !== 1'b0 || readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b readdata=%h irq=%b, expected 0/0/0", ready, readdata, irq);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Reset-state read, then one-shot countdown with irq
    do_req(1, 0, 2'd3, '0, 4'hF);
    do_req(0, 1, 2'd1, 32'h3, 4'hF);
    do_req(0, 1, 2'd0, 32'h5, 4'hF);
    for (int i = 0; i < 3; i++) do_req(1, 0, 2'd2, '0, 4'hF);
    do_req(1, 0, 2'd3, '0, 4'hF);
    do_req(1, 0, 2'd0, '0, 4'hF);

    // Byte-lane writes, empty strobe, expired clear, read+write collision, COUNT write
    do_req(0, 1, 2'd1, 32'hAABBCCDD, 4'hF);
    do_req(0, 1, 2'd1, 32'h11223344, 4'b0101);
    do_req(1, 0, 2'd1, '0, 4'hF);
    do_req(0, 1, 2'd1, 32'h12345678, 4'b0000);
    do_req(1, 0, 2'd1, '0, 4'hF);
    do_req(0, 1, 2'd3, 32'h1, 4'h1);
    do_req(1, 0, 2'd3, '0, 4'hF);
    do_req(1, 1, 2'd1, 32'h7, 4'hF);
    do_req(1, 0, 2'd1, '0, 4'hF);
    do_req(0, 1, 2'd2, 32'hDEAD, 4'hF);
    do_req(1, 0, 2'd2, '0, 4'hF);

    // Auto-reload: land a STATUS clear exactly on an expiry edge
    do_req(0, 1, 2'd1, 32'h2, 4'hF);
    do_req(0, 1, 2'd0, 32'h7, 4'hF);
    hit = 0;
    for (int t = 0; t < 20 && !hit; t++) begin
      mstate_t s1, s2;
      bit e1, e2;
      s1 = step(m, 0, 2'd0, '0, '0, e1);
      s2 = step(s1, 0, 2'd0, '0, '0, e2);
      if (e2) begin
        do_req(0, 1, 2'd3, 32'h1, 4'hF);
        hit = 1;
      end else begin
        tick(0, 2'd0, '0, '0);
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL w1c_collision: no expiry edge found, got 0 expected 1");
    end
    do_req(1, 0, 2'd3, '0, 4'hF);
    do_req(1, 0, 2'd2, '0, 4'hF);
    do_req(0, 1, 2'd0, 32'h0, 4'hF);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  a;
      logic [31:0] d;
      int          op;
      a  = 2'($urandom());
      op = $urandom_range(0, 9);
      d  = $urandom();
      if (a == 2'd1 && $urandom_range(0, 3) != 0) d = d & 32'h7;
      if (op < 5)      do_req(1, 0, a, '0, 4'($urandom()));
      else if (op < 9) do_req(0, 1, a, d, 4'($urandom()));
      else             do_req(1, 1, a, d, 4'($urandom()));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Make irq visible, then reset in the middle of a LOAD write's response cycle
    do_req(0, 1, 2'd1, 32'h0, 4'hF);
    do_req(0, 1, 2'd0, 32'h5, 4'hF);
    repeat (3) tick(0, 2'd0, '0, '0);
    enable = 1; read = 0; write = 1; address = 32'h1; writedata = 32'h55; byte_enable = 4'hF;
    @(posedge clk);
    #1 rst_n = 0;
    m = '0;
    #1;
    checks++;
    if (ready !== 1'b0 || readdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_resp: ready=%b readdata=%h irq=%b, expected 0/0/0", ready, readdata, irq);
    end
    enable = 0; write = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) do_req(1, 0, 2'(i), '0, 4'hF);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still outstanding, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
